// File: rtl/nano_mem_resp.sv
// nano_mem_resp: memory-side responder for the NanoCPU bus, owning a 2**ADDR_W x DATA_W RAM.
// Latency: CPU reads are combinational (zero cycles); writes and loads commit on the rising edge of ck.
// Backpressure: ld_ready is high only in LOAD, and load words are accepted every cycle there; CPU accesses are never stalled.
//
// Optional feature macro: NANO_MEM_PROT_EN. When defined, CPU writes at or above PROT_BASE are
// blocked and flagged through viol/viol_addr. When undefined, every address is writable and
// viol/viol_addr are tied to 0.
//
// Ports:
//   ck, rst                 clock (rising edge) and asynchronous active-low reset
//   address/dataW/ce/we     CPU access; a write needs ce=1 and we=1
//   dataR                   CPU read data, mem[address] in RUN and 0 in LOAD
//   ld_valid/ld_ready       host load handshake, with ld_addr/ld_data as the word to load
//   ld_done                 host pulse that ends loading and moves the FSM to RUN
//   cpu_hold                high in LOAD; the top level holds the CPU in reset with it
//   wr_count                accepted CPU writes, saturating at all-ones
//   viol/viol_addr          sticky protected-write flag and the address of the first violation
module nano_mem_resp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hF0
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataW,
  input  logic              ce,
  input  logic              we,
  output logic [DATA_W-1:0] dataR,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              cpu_hold,
  output logic [15:0]       wr_count,
  output logic              viol,
  output logic [ADDR_W-1:0] viol_addr
);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nx;

  // The RAM is deliberately outside the reset domain so that a loaded image survives reset.
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic              load_wr;   // host word to commit this cycle
  logic              cpu_wr;    // CPU write attempt in RUN
  logic              cpu_ok;    // CPU write that is allowed to land
  logic              prot_hit;  // address falls in the protected top region
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_ready = 1'b0;
    cpu_hold = 1'b0;
    load_wr  = 1'b0;
    cpu_wr   = 1'b0;
    if (state == LOAD) begin
      ld_ready = 1'b1;
      cpu_hold = 1'b1;
      load_wr  = ld_valid;
      // A word arriving together with ld_done still lands on the same edge.
      if (ld_done) state_nx = RUN;
    end else begin
      cpu_wr = ce & we;
    end
  end

  assign prot_hit = (address >= PROT_BASE);

`ifdef NANO_MEM_PROT_EN
  logic viol_hit;
  assign cpu_ok   = cpu_wr & ~prot_hit;
  assign viol_hit = cpu_wr & prot_hit;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      viol      <= 1'b0;
      viol_addr <= '0;
    end else if (viol_hit) begin
      viol <= 1'b1;
      // Only the first offender is recorded; later hits leave the address alone.
      if (!viol) viol_addr <= address;
    end
  end
`else
  logic unused_prot_hit;
  assign unused_prot_hit = prot_hit;
  assign cpu_ok          = cpu_wr;
  assign viol            = 1'b0;
  assign viol_addr       = '0;
`endif

  // Load and CPU writes are mutually exclusive by state, so one shared write port suffices.
  assign wr_addr = load_wr ? ld_addr : address;
  assign wr_data = load_wr ? ld_data : dataW;

  // Gating with rst drops any write presented on an edge while reset is held.
  always_ff @(posedge ck) begin
    if (rst && (load_wr || cpu_ok)) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst)                          wr_count <= '0;
    else if (cpu_ok && wr_count != '1) wr_count <= wr_count + 16'd1;
  end

  // Read-during-write returns the old word because the array only updates on the edge.
  assign dataR = (state == RUN) ? mem[address] : '0;

endmodule

// File: tb/tb_nano_mem_resp.sv
module tb_nano_mem_resp;

`ifdef NANO_MEM_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        ck = 1'b0;
  logic        rst;
  logic [7:0]  address, ld_addr, viol_addr;
  logic [15:0] dataW, dataR, ld_data, wr_count;
  logic        ce, we, ld_valid, ld_ready, ld_done, cpu_hold, viol;

  // Reference model: plain array plus the status the bus should expose.
  logic [15:0] m_mem [256];
  bit          m_run;
  int          m_cnt;
  bit          m_viol;
  logic [7:0]  m_vaddr;

  int n_tests = 0;
  int n_fail  = 0;

  nano_mem_resp dut (
    .ck(ck), .rst(rst), .address(address), .dataW(dataW), .ce(ce), .we(we),
    .dataR(dataR), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done), .cpu_hold(cpu_hold), .wr_count(wr_count),
    .viol(viol), .viol_addr(viol_addr)
  );

  always #5 ck = ~ck;

  function automatic logic [15:0] exp_rd(input logic [7:0] a);
    return m_run ? m_mem[a] : 16'h0000;
  endfunction

  task automatic idle();
    ce = 0; we = 0; address = 0; dataW = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0; ld_done = 0;
  endtask

  // Applies the model's view of the current inputs, then crosses one rising edge.
  // Entered and left just after a falling edge; rst is high throughout.
  task automatic step();
    if (!m_run) begin
      if (ld_valid) m_mem[ld_addr] = ld_data;
      if (ld_done)  m_run = 1;
    end else if (ce && we) begin
      if (PROT && address >= 8'hF0) begin
        if (!m_viol) m_vaddr = address;
        m_viol = 1;
      end else begin
        m_mem[address] = dataW;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    m_run = 0; m_cnt = 0; m_viol = 0; m_vaddr = 0;
    @(negedge ck);
    rst = 1;
    @(negedge ck);
  endtask

  task automatic go_run();
    idle();
    ld_done = 1;
    step();
    ld_done = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #1;
    m_run = 0; m_cnt = 0; m_viol = 0; m_vaddr = 0;
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ld_ready got=%b exp=1", ld_ready); end
    n_tests++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
    n_tests++; if (wr_count !== 16'h0) begin n_fail++; $display("FAIL rst_wr_count got=%h exp=0", wr_count); end
    n_tests++; if (viol !== 1'b0) begin n_fail++; $display("FAIL rst_viol got=%b exp=0", viol); end
    n_tests++; if (viol_addr !== 8'h0) begin n_fail++; $display("FAIL rst_viol_addr got=%h exp=0", viol_addr); end
    n_tests++; if (dataR !== 16'h0) begin n_fail++; $display("FAIL rst_dataR got=%h exp=0", dataR); end
    @(negedge ck);
    rst = 1;
    @(negedge ck);
  endtask

  task automatic test_load_run();
    logic [7:0]  sa [5];
    logic [15:0] sd [5];
    sa = '{8'd0, 8'd1, 8'd2, 8'd30, 8'd31};
    sd = '{16'h01E0, 16'h01F1, 16'hF000, 16'h1111, 16'h2222};
    // Whole RAM gets a random image; CPU traffic during LOAD must be ignored.
    for (int i = 0; i < 256; i++) begin
      idle();
      ld_valid = 1; ld_addr = i[7:0]; ld_data = 16'($urandom);
      ce = 1'($urandom); we = 1'($urandom); address = 8'($urandom); dataW = 16'($urandom);
      #1;
      if (i % 32 == 0) begin
        n_tests++; if (dataR !== 16'h0) begin n_fail++; $display("FAIL load_dataR a=%h got=%h exp=0", address, dataR); end
      end
      step();
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      ld_valid = 1; ld_addr = sa[i]; ld_data = sd[i];
      step();
    end
    idle();
    ld_done = 1;
    #1;
    n_tests++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL pre_done_hold got=%b exp=1", cpu_hold); end
    step();
    idle();
    address = 8'd30;
    #1;
    n_tests++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL run_cpu_hold got=%b exp=0", cpu_hold); end
    n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL run_ld_ready got=%b exp=0", ld_ready); end
    n_tests++; if (dataR !== 16'h1111) begin n_fail++; $display("FAIL rd_30 got=%h exp=1111", dataR); end
    for (int i = 0; i < 5; i++) begin
      address = sa[i];
      #1;
      n_tests++; if (dataR !== sd[i]) begin n_fail++; $display("FAIL rd_img a=%h got=%h exp=%h", sa[i], dataR, sd[i]); end
    end
    // Spot-check the random part of the image, which also proves LOAD-time CPU writes were dropped.
    for (int i = 0; i < 8; i++) begin
      address = 8'($urandom_range(32, 255));
      #1;
      n_tests++; if (dataR !== exp_rd(address)) begin n_fail++; $display("FAIL rd_rand a=%h got=%h exp=%h", address, dataR, exp_rd(address)); end
    end
  endtask

  task automatic test_run_handshake();
    logic [15:0] old5;
    old5 = m_mem[5];
    idle();
    ld_valid = 1; ld_addr = 8'd5; ld_data = 16'hABCD;
    #1;
    n_tests++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL hs_ld_ready got=%b exp=0", ld_ready); end
    step();
    idle();
    address = 8'd5;
    #1;
    n_tests++; if (dataR !== old5) begin n_fail++; $display("FAIL hs_mem5 got=%h exp=%h", dataR, old5); end
  endtask

  task automatic test_cpu_write();
    logic [15:0] old;
    idle();
    old = m_mem[8'h40];
    ce = 1; we = 1; address = 8'h40; dataW = 16'h5A5A;
    #1;
    n_tests++; if (dataR !== old) begin n_fail++; $display("FAIL wr_old got=%h exp=%h", dataR, old); end
    step();
    idle();
    address = 8'h40;
    #1;
    n_tests++; if (dataR !== 16'h5A5A) begin n_fail++; $display("FAIL wr_new got=%h exp=5a5a", dataR); end
    n_tests++; if (wr_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL wr_count got=%h exp=%h", wr_count, 16'(m_cnt)); end
    ce = 0; we = 1; dataW = 16'h1234;
    step();
    idle();
    address = 8'h40;
    #1;
    n_tests++; if (dataR !== 16'h5A5A) begin n_fail++; $display("FAIL nce_data got=%h exp=5a5a", dataR); end
    n_tests++; if (wr_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL nce_count got=%h exp=%h", wr_count, 16'(m_cnt)); end
  endtask

  task automatic test_protect();
    logic [7:0] pa [2];
    pa = '{8'hF5, 8'hF8};
    do_reset();
    go_run();
    for (int i = 0; i < 2; i++) begin
      idle();
      ce = 1; we = 1; address = pa[i]; dataW = 16'($urandom);
      step();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      address = pa[i];
      #1;
      n_tests++; if (dataR !== m_mem[pa[i]]) begin n_fail++; $display("FAIL prot_mem a=%h got=%h exp=%h", pa[i], dataR, m_mem[pa[i]]); end
    end
    n_tests++; if (viol !== m_viol) begin n_fail++; $display("FAIL prot_viol got=%b exp=%b", viol, m_viol); end
    n_tests++; if (viol_addr !== m_vaddr) begin n_fail++; $display("FAIL prot_vaddr got=%h exp=%h", viol_addr, m_vaddr); end
    n_tests++; if (wr_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL prot_count got=%h exp=%h", wr_count, 16'(m_cnt)); end
  endtask

  task automatic test_random_run();
    for (int i = 0; i < 300; i++) begin
      idle();
      ce = 1'($urandom); we = 1'($urandom); dataW = 16'($urandom);
      address = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom);
      ld_valid = 1'($urandom); ld_addr = address; ld_data = 16'($urandom);
      #1;
      n_tests++; if (dataR !== exp_rd(address)) begin n_fail++; $display("FAIL rnd_rd i=%0d a=%h got=%h exp=%h", i, address, dataR, exp_rd(address)); end
      step();
      n_tests++; if (wr_count !== 16'(m_cnt) || viol !== m_viol || viol_addr !== m_vaddr) begin
        n_fail++;
        $display("FAIL rnd_stat i=%0d got=%h/%b/%h exp=%h/%b/%h", i, wr_count, viol, viol_addr, 16'(m_cnt), m_viol, m_vaddr);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] wa [3];
    do_reset();
    go_run();
    for (int i = 0; i < 3; i++) begin
      idle();
      wa[i] = 8'($urandom_range(0, 8'hEF));
      ce = 1; we = 1; address = wa[i]; dataW = 16'($urandom);
      step();
    end
    idle();
    n_tests++; if (wr_count !== 16'd3) begin n_fail++; $display("FAIL mid_pre_count got=%h exp=3", wr_count); end
    #2;
    rst = 0;
    #1;
    m_run = 0; m_cnt = 0; m_viol = 0; m_vaddr = 0;
    n_tests++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_hold got=%b exp=1", cpu_hold); end
    n_tests++; if (wr_count !== 16'h0) begin n_fail++; $display("FAIL mid_count got=%h exp=0", wr_count); end
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ld_ready got=%b exp=1", ld_ready); end
    @(negedge ck);
    rst = 1;
    @(negedge ck);
    go_run();
    for (int i = 0; i < 3; i++) begin
      address = wa[i];
      #1;
      n_tests++; if (dataR !== m_mem[wa[i]]) begin n_fail++; $display("FAIL mid_keep a=%h got=%h exp=%h", wa[i], dataR, m_mem[wa[i]]); end
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    idle();
    ld_valid = 1; ld_addr = 8'h22; ld_data = ~m_mem[8'h22];
    #2;
    rst = 0;
    @(negedge ck);
    idle();
    rst = 1;
    @(negedge ck);
    go_run();
    address = 8'h22;
    #1;
    n_tests++; if (dataR !== m_mem[8'h22]) begin n_fail++; $display("FAIL rstload_drop got=%h exp=%h", dataR, m_mem[8'h22]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    do_reset();
    idle();
    d = 16'($urandom);
    ld_valid = 1; ld_addr = 8'hFF; ld_data = d; ld_done = 1;
    step();
    idle();
    address = 8'hFF;
    #1;
    n_tests++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL b2b_hold got=%b exp=0", cpu_hold); end
    n_tests++; if (dataR !== d) begin n_fail++; $display("FAIL b2b_ff got=%h exp=%h", dataR, d); end
  endtask

  task automatic test_saturation();
    do_reset();
    go_run();
    idle();
    ce = 1; we = 1; address = 8'h10; dataW = 16'h7777;
    for (int i = 0; i < 65534; i++) step();
    n_tests++; if (wr_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe got=%h exp=fffe", wr_count); end
    step();
    n_tests++; if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff got=%h exp=ffff", wr_count); end
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", wr_count); end
    idle();
  endtask

  initial begin
    rst = 0;
    idle();
    @(negedge ck);
    test_reset();
    test_load_run();
    test_run_handshake();
    test_cpu_write();
    test_protect();
    test_random_run();
    test_reset_mid_run();
    test_reset_mid_load();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
